// File: rtl/wts_wave_ram_if.sv
// Bus bundle for the wave-table RAM: CPU req/ack port, sound-engine read port, and the clear status.
interface wts_wave_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_a;
    logic [DATA_W-1:0] cpu_d;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_q;
    logic              snd_req;
    logic [ADDR_W-1:0] snd_a;
    logic              snd_valid;
    logic [DATA_W-1:0] snd_q;
    logic              init_busy;

    modport master (
        output cpu_req, cpu_we, cpu_a, cpu_d, snd_req, snd_a,
        input  cpu_ack, cpu_q, snd_valid, snd_q, init_busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_a, cpu_d, snd_req, snd_a,
        output cpu_ack, cpu_q, snd_valid, snd_q, init_busy
    );
endinterface

// File: rtl/wts_wave_ram.sv
// Wave-table sample RAM: single array, one access per clock, sound-priority arbitration with a
// CPU anti-starvation slot, and a zero-fill sweep after every reset.
module wts_wave_ram #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 9,
    parameter int DEPTH      = 384,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    wts_wave_ram_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_a, clr_a_nxt;
    logic [SW-1:0]     starve_cnt, starve_nxt;
    logic              cpu_elig, cpu_win, snd_win;
    logic              mem_we, in_range;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d, rd_data;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_nxt  = state;
        clr_a_nxt  = clr_a;
        starve_nxt = starve_cnt;
        cpu_win    = 1'b0;
        snd_win    = 1'b0;
        mem_we     = 1'b0;
        mem_a      = bus.snd_a;
        mem_d      = bus.cpu_d;
        // The ack cycle itself is never eligible, so a held request cannot be re-granted early.
        cpu_elig   = bus.cpu_req && !bus.cpu_ack;
        case (state)
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_a  = clr_a;
                mem_d  = '0;
                if (clr_a == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
                else                             clr_a_nxt = clr_a + 1'b1;
            end
            ST_RUN: begin
                cpu_win = cpu_elig && (!bus.snd_req || starve_cnt == SW'(STARVE_MAX));
                snd_win = bus.snd_req && !cpu_win;
                if (cpu_win) begin
                    mem_a      = bus.cpu_a;
                    mem_we     = bus.cpu_we;
                    starve_nxt = '0;
                end else if (cpu_elig && starve_cnt != SW'(STARVE_MAX)) begin
                    starve_nxt = starve_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
        in_range = {1'b0, mem_a} < DEPTH_W;
        rd_data  = in_range ? mem[mem_a] : '0;
    end

    assign bus.init_busy = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (mem_we && in_range && !reset) mem[mem_a] <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_CLEAR;
            clr_a         <= '0;
            starve_cnt    <= '0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_q     <= '0;
            bus.snd_valid <= 1'b0;
            bus.snd_q     <= '0;
        end else begin
            state         <= state_nxt;
            clr_a         <= clr_a_nxt;
            starve_cnt    <= starve_nxt;
            bus.cpu_ack   <= cpu_win;
            bus.snd_valid <= snd_win;
            if (cpu_win && !bus.cpu_we) bus.cpu_q <= rd_data;
            if (snd_win)                bus.snd_q <= rd_data;
        end
    end
endmodule
